// File: rtl/seg_scan_3digit.sv
// Three-digit multiplexed 7-segment scanner with per-slot dead time and a frame snapshot.
// Outputs are registered: each output register holds the value for the FSM state it is entering.
module seg_scan_3digit #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] digits,
  input  logic [2:0]  dp,
  input  logic        blank_lz,
  output logic [7:0]  seg_n,
  output logic [2:0]  an_n
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic        rst_q;
  logic [11:0] snap_dig_q, snap_dig_d;
  logic [2:0]  snap_dp_q, snap_dp_d;
  logic        snap_blz_q, snap_blz_d;
  logic [7:0]  seg_q, seg_d;
  logic [2:0]  an_q, an_d;

  logic [3:0]  nib;
  logic        lz_blank;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b0111111;
    endcase
  endfunction

  // Slot sequencing. The cycle right after reset release restarts the slot
  // at count 0 so the first BLANK lasts BLANK_CYCLES from the release edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_blz_d = snap_blz_q;
    if (rst_q) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else if (cnt_q == SLOT_LAST) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      if (digit_q == 2'd2) begin
        digit_d    = 2'd0;
        snap_dig_d = digits;
        snap_dp_d  = dp;
        snap_blz_d = blank_lz;
      end else begin
        digit_d = digit_q + 2'd1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == S_BLANK && cnt_q == BLANK_LAST) begin
        state_d = S_ON;
      end
    end
  end

  always_comb begin
    nib      = 4'd0;
    lz_blank = 1'b0;
    case (digit_d)
      2'd0:    nib = snap_dig_d[3:0];
      2'd1: begin
        nib      = snap_dig_d[7:4];
        lz_blank = snap_blz_d && (snap_dig_d[11:4] == 8'h00);
      end
      default: begin
        nib      = snap_dig_d[11:8];
        lz_blank = snap_blz_d && (snap_dig_d[11:8] == 4'h0);
      end
    endcase
    seg_d = 8'hFF;
    an_d  = 3'b111;
    if (state_d == S_ON) begin
      an_d  = ~(3'b001 << digit_d);
      seg_d = {~snap_dp_d[digit_d], lz_blank ? 7'h7F : dec7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      state_q    <= S_BLANK;
      cnt_q      <= '0;
      digit_q    <= 2'd0;
      snap_dig_q <= digits;
      snap_dp_q  <= dp;
      snap_blz_q <= blank_lz;
      seg_q      <= 8'hFF;
      an_q       <= 3'b111;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_blz_q <= snap_blz_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;

endmodule

// File: doc/seg_scan_3digit.md
SEG_SCAN_3DIGIT -- requirements
Module: seg_scan_3digit

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, dead-time cycles at the start of each slot; legal range 1..SLOT_CYCLES-2.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port digits, input, 12, BCD nibbles: [3:0] digit 0 (rightmost), [7:4] digit 1, [11:8] digit 2; [7:0] connects directly to the 0-59 seconds counter q output.
REQ-006 SHALL have port dp, input, 3, decimal point request per digit; bit n maps to digit n.
REQ-007 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-008 SHALL have port seg_n, output, 8, active-low segments: [7] dp, [6:0] g,f,e,d,c,b,a.
REQ-009 SHALL have port an_n, output, 3, active-low digit enables; bit n drives digit n.

Function
REQ-010 SHALL drive seg_n and an_n from registers only; no combinational path from any input to any output.
REQ-011 SHALL scan digit 0, then 1, then 2, then back to 0; each digit gets exactly one slot of SLOT_CYCLES cycles, so a frame is 3*SLOT_CYCLES cycles.
REQ-012 SHALL run a two-state FSM per slot: BLANK for BLANK_CYCLES cycles, then ON for SLOT_CYCLES-BLANK_CYCLES cycles; ON of the last digit moves to BLANK of the next digit.
REQ-013 SHALL hold an_n = 3'b111 and seg_n = 8'hFF throughout BLANK (anti-ghosting).
REQ-014 SHALL, in ON for digit n, drive an_n with only bit n low and seg_n with the decoded pattern of snapshot digit n.
REQ-015 SHALL load a 15-bit snapshot of {dp, digits} on the cycle the FSM enters BLANK of digit 0; all three digits shown in one frame come from that snapshot, so a 59->00 rollover never displays a torn value.
REQ-016 SHALL decode 0-9 to the standard patterns (seg_n[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 SHALL decode nibble values A-F to a minus sign (seg_n[6:0] = 0111111), flagging the invalid BCD.
REQ-018 SHALL, when blank_lz=1, blank digit 2 if its snapshot value is 0, and blank digit 1 if digits 2 and 1 are both 0; digit 0 is never blanked.
REQ-019 SHALL sample blank_lz with the snapshot, not live.
REQ-020 SHALL, for a blanked digit, drive seg_n[6:0] = 7'h7F and keep the digit enabled in ON; seg_n[7] still follows dp.
REQ-021 SHALL drive seg_n[7] = ~dp_snapshot[n] in ON, independent of the digit value.
REQ-022 SHALL never assert more than one an_n bit low in any cycle, including the slot-boundary cycles.

Reset
REQ-023 SHALL, while reset=1, force an_n=3'b111, seg_n=8'hFF, FSM=BLANK, digit index=0, slot counter=0, and load the snapshot from the live inputs every cycle.
REQ-024 SHALL, on the first clk edge after reset deasserts, start BLANK of digit 0 with BLANK_CYCLES counted from that edge and no further snapshot load until the next frame.
REQ-025 SHALL abort the current slot immediately when reset asserts mid-frame; outputs are blank on the next clk edge.

Verification (SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-026 SHALL cover: digits=12'h059, dp=0, blank_lz=0 after reset -> per slot 2 cycles an_n=111, then 6 cycles an_n=110/seg_n=8'h90, then 101/8'h92, then 011/8'hC0; frame length 24 cycles.
REQ-027 SHALL cover: same stimulus with blank_lz=1 -> digit 2 slot shows an_n=011, seg_n=8'hFF; digits=12'h005 -> digits 2 and 1 both blanked.
REQ-028 SHALL cover: digits changed 12'h059->12'h100 mid-frame during digit 1 ON -> digit 2 still shows 0 in that frame; the new value appears only from the next frame's digit 0.
REQ-029 SHALL cover: digits=12'h0A3, dp=3'b010 -> digit 1 shows seg_n=8'h3F (minus with dp); digit 0 shows 8'hB0.
REQ-030 SHALL cover: reset pulsed for 1 cycle during digit 2 ON -> next cycle an_n=111, seg_n=FF; scan restarts at digit 0 after exactly 2 blank cycles.
REQ-031 SHALL cover: an assertion over 10 full frames that an_n is never 3'b000, 3'b001, 3'b010 or 3'b100 (at most one digit enabled).
